// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: entry layout and
// 2-bit direction counter encoding and update rule.
package bp_pkg;

    // Entry fields are sized for the widest supported PC; narrower tags are zero-extended.
    localparam int BP_XLEN = 32;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    typedef struct packed {
        logic               valid;
        logic [BP_XLEN-1:0] tag;
        logic [BP_XLEN-1:0] target;
        logic [1:0]         ctr;
        logic               jump;
    } bp_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == CTR_ST) ? ctr : ctr + 2'd1;
        else
            return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Width-parametrised saturating up/down counter with enable and synchronous
// active-low clear; holds at all-ones going up and at zero going down.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en) begin
            if (up && count != '1)
                count <= count + WIDTH'(1);
            else if (!up && count != '0)
                count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency fetch lookup,
// execute-stage resolve/redirect, table training and saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n_i,
    input  logic [DATA_WIDTH-1:0]  pc_f_i,
    output logic                   predict_taken_f_o,
    output logic [DATA_WIDTH-1:0]  next_pc_f_o,
    input  logic                   update_en_e_i,
    input  logic                   is_jump_e_i,
    input  logic                   is_jalr_e_i,
    input  logic [DATA_WIDTH-1:0]  pc_e_i,
    input  logic                   taken_e_i,
    input  logic [DATA_WIDTH-1:0]  target_e_i,
    input  logic                   pred_taken_e_i,
    input  logic [DATA_WIDTH-1:0]  pred_target_e_i,
    output logic                   mispredict_e_o,
    output logic [DATA_WIDTH-1:0]  redirect_pc_e_o,
    output logic [COUNT_WIDTH-1:0] branch_count_o,
    output logic [COUNT_WIDTH-1:0] mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;

    bp_entry_t table_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    bp_entry_t             entry_f, entry_e;
    logic                  hit_f, hit_e;

    assign idx_f = pc_f_i[INDEX_BITS+1:2];
    assign tag_f = pc_f_i[DATA_WIDTH-1:INDEX_BITS+2];
    assign idx_e = pc_e_i[INDEX_BITS+1:2];
    assign tag_e = pc_e_i[DATA_WIDTH-1:INDEX_BITS+2];

    assign entry_f = table_q[idx_f];
    assign entry_e = table_q[idx_e];
    assign hit_f   = entry_f.valid && (entry_f.tag == BP_XLEN'(tag_f));
    assign hit_e   = entry_e.valid && (entry_e.tag == BP_XLEN'(tag_e));

    // Lookup reads the registered table, so a same-cycle update is not yet visible.
    assign predict_taken_f_o = hit_f && (entry_f.jump || entry_f.ctr[1]);
    assign next_pc_f_o       = predict_taken_f_o ? DATA_WIDTH'(entry_f.target)
                                                 : pc_f_i + DATA_WIDTH'(4);

    always_comb begin
        mispredict_e_o  = 1'b0;
        redirect_pc_e_o = pc_e_i + DATA_WIDTH'(4);
        if (update_en_e_i) begin
            mispredict_e_o = is_jalr_e_i
                          || (pred_taken_e_i != taken_e_i)
                          || (taken_e_i && (pred_target_e_i != target_e_i));
            if (taken_e_i)
                redirect_pc_e_o = target_e_i;
        end
    end

    // jalr targets are register-dependent, so they never enter the table.
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++)
                table_q[i] <= '0;
        end else if (update_en_e_i && !is_jalr_e_i) begin
            if (hit_e) begin
                table_q[idx_e].ctr <= ctr_step(entry_e.ctr, taken_e_i);
                if (taken_e_i)
                    table_q[idx_e].target <= BP_XLEN'(target_e_i);
            end else if (taken_e_i) begin
                table_q[idx_e] <= '{valid:  1'b1,
                                   tag:    BP_XLEN'(tag_e),
                                   target: BP_XLEN'(target_e_i),
                                   ctr:    CTR_ALLOC,
                                   jump:   is_jump_e_i};
            end
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .clr_n (rst_n_i),
        .en    (update_en_e_i),
        .up    (1'b1),
        .count (branch_count_o)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_mispredict_cnt (
        .clk   (clk),
        .clr_n (rst_n_i),
        .en    (mispredict_e_o),
        .up    (1'b1),
        .count (mispredict_count_o)
    );

endmodule
